// File: rtl/br_resolve_if.sv
// Bundle between fetch, the execute-stage branch unit, the predictor update port
// and the pipeline flush logic, as seen by br_resolve_ctrl.
interface br_resolve_if;
  logic        fetch_valid;
  logic [1:0]  fetch_index;
  logic        fetch_predict;
  logic [31:0] fetch_target;
  logic [31:0] fetch_npc;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_en;
  logic        upd_taken;
  logic [1:0]  upd_index;
  logic [31:0] upd_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        full;
  logic        empty;
  logic        err;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  modport master (
    output fetch_valid, fetch_index, fetch_predict, fetch_target, fetch_npc,
    output res_valid, res_taken, res_target,
    input  upd_en, upd_taken, upd_index, upd_target, flush, redirect_pc,
    input  full, empty, err, br_count, mp_count
  );

  modport slave (
    input  fetch_valid, fetch_index, fetch_predict, fetch_target, fetch_npc,
    input  res_valid, res_taken, res_target,
    output upd_en, upd_taken, upd_index, upd_target, flush, redirect_pc,
    output full, empty, err, br_count, mp_count
  );
endinterface

// File: rtl/br_resolve_ctrl.sv
// Branch resolve sequencer: in-order queue of fetch-time predictions, checked
// against execute outcomes to drive predictor updates and mispredict flushes.
//
// state    | meaning
// ST_RUN   | normal operation, pushes and pops accepted
// ST_FLUSH | flush held, fetch and resolve ignored until the counter expires
module br_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input logic        clk_i,
  input logic        rst_ni,
  br_resolve_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_LD  = CW'(FLUSH_CYCLES);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          upd_en_q, upd_taken_q, flush_q, err_q;
  logic [1:0]    upd_index_q;
  logic [31:0]   upd_target_q, redirect_q;
  logic [15:0]   br_cnt_q, mp_cnt_q;

  logic [1:0]    idx_mem  [DEPTH];
  logic          pred_mem [DEPTH];
  logic [31:0]   tgt_mem  [DEPTH];
  logic [31:0]   npc_mem  [DEPTH];

  logic [AW-1:0] rd_idx, wr_idx;
  logic          full_w, empty_w, run_w, pop_w, push_w, mispred_w, ovf_w, unf_w;

  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign run_w   = (state_q == ST_RUN);

  assign pop_w     = run_w && bus.res_valid && !empty_w;
  assign mispred_w = pop_w && ((pred_mem[rd_idx] != bus.res_taken) ||
                     (pred_mem[rd_idx] && bus.res_taken && (tgt_mem[rd_idx] != bus.res_target)));
  // A correct pop frees the slot the push lands in; a mispredict squashes the push.
  assign push_w    = run_w && bus.fetch_valid && (!full_w || pop_w) && !mispred_w;
  assign ovf_w     = run_w && bus.fetch_valid && full_w && !pop_w;
  assign unf_w     = run_w && bus.res_valid && empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (mispred_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_w) begin
      idx_mem[wr_idx]  <= bus.fetch_index;
      pred_mem[wr_idx] <= bus.fetch_predict;
      tgt_mem[wr_idx]  <= bus.fetch_target;
      npc_mem[wr_idx]  <= bus.fetch_npc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      upd_en_q     <= 1'b0;
      upd_taken_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_target_q <= '0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      err_q        <= 1'b0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      upd_en_q <= 1'b0;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (ovf_w || unf_w) err_q <= 1'b1;
      case (state_q)
        ST_RUN: begin
          if (pop_w) begin
            upd_en_q     <= 1'b1;
            upd_taken_q  <= bus.res_taken;
            upd_index_q  <= idx_mem[rd_idx];
            upd_target_q <= bus.res_target;
            if (br_cnt_q != 16'hFFFF) br_cnt_q <= br_cnt_q + 16'd1;
          end
          if (mispred_w) begin
            if (mp_cnt_q != 16'hFFFF) mp_cnt_q <= mp_cnt_q + 16'd1;
            flush_q    <= 1'b1;
            redirect_q <= bus.res_taken ? bus.res_target : npc_mem[rd_idx];
            cnt_q      <= CNT_LD;
            state_q    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == CNT_ONE) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.upd_en      = upd_en_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.upd_index   = upd_index_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.err         = err_q;
  assign bus.br_count    = br_cnt_q;
  assign bus.mp_count    = mp_cnt_q;
endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: directed vector table, corner sequences, and random
// traffic checked against a queue-level reference model.
module tb_br_resolve_ctrl;
  localparam int DEPTH = 4;
  localparam int FC    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  br_resolve_if bif();
  br_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  idx;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] npc;
  } ent_t;

  typedef struct {
    logic        fv;
    logic [1:0]  fi;
    logic        fp;
    logic [31:0] ft;
    logic [31:0] fn;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    logic [103:0] exp;
  } vec_t;

  // reference model state
  ent_t        mq[$];
  int          m_fl;
  logic        m_upd_en, m_upd_taken, m_flush, m_err;
  logic [1:0]  m_upd_index;
  logic [31:0] m_upd_target, m_redir;
  logic [15:0] m_br, m_mp;

  vec_t vt[$];
  logic [103:0] rst_v;

  function automatic logic [103:0] pack(input logic ue, input logic ut, input logic [1:0] ui,
      input logic [31:0] utg, input logic fl, input logic [31:0] rd, input logic fu,
      input logic em, input logic er, input logic [15:0] br, input logic [15:0] mp);
    return {ue, ut, ui, utg, fl, rd, fu, em, er, br, mp};
  endfunction

  function automatic logic [103:0] dut_vec();
    return pack(bif.upd_en, bif.upd_taken, bif.upd_index, bif.upd_target, bif.flush,
                bif.redirect_pc, bif.full, bif.empty, bif.err, bif.br_count, bif.mp_count);
  endfunction

  function automatic logic [103:0] mdl_vec();
    return pack(m_upd_en, m_upd_taken, m_upd_index, m_upd_target, m_flush, m_redir,
                mq.size() == DEPTH, mq.size() == 0, m_err, m_br, m_mp);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_fl = 0;
    m_upd_en = 0; m_upd_taken = 0; m_upd_index = 0; m_upd_target = 0;
    m_flush = 0; m_redir = 0; m_err = 0; m_br = 0; m_mp = 0;
  endfunction

  function automatic void model_step();
    ent_t h;
    ent_t e;
    logic mis;
    m_upd_en = 0;
    if (m_fl > 0) begin
      m_fl--;
      if (m_fl == 0) begin
        m_flush = 0;
        m_redir = 0;
      end
      return;
    end
    mis = 0;
    if (bif.res_valid) begin
      if (mq.size() == 0) m_err = 1;
      else begin
        h = mq.pop_front();
        m_upd_en = 1;
        m_upd_taken = bif.res_taken;
        m_upd_index = h.idx;
        m_upd_target = bif.res_target;
        if (m_br != 16'hFFFF) m_br++;
        if (h.pred != bif.res_taken || (h.pred && bif.res_taken && h.tgt != bif.res_target)) begin
          mis = 1;
          if (m_mp != 16'hFFFF) m_mp++;
          m_flush = 1;
          m_redir = bif.res_taken ? bif.res_target : h.npc;
          m_fl = FC;
          mq.delete();
        end
      end
    end
    if (bif.fetch_valid && !mis) begin
      if (mq.size() < DEPTH) begin
        e.idx = bif.fetch_index; e.pred = bif.fetch_predict;
        e.tgt = bif.fetch_target; e.npc = bif.fetch_npc;
        mq.push_back(e);
      end else m_err = 1;
    end
  endfunction

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [1:0] fi, input logic fp, input logic [31:0] ft,
      input logic [31:0] fn, input logic rv, input logic rt, input logic [31:0] rtg);
    bif.fetch_valid = fv; bif.fetch_index = fi; bif.fetch_predict = fp;
    bif.fetch_target = ft; bif.fetch_npc = fn;
    bif.res_valid = rv; bif.res_taken = rt; bif.res_target = rtg;
  endtask

  task automatic step(input string name);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check(name, dut_vec(), mdl_vec());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("rst_async", dut_vec(), rst_v);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", dut_vec(), rst_v);
    rst_n = 1'b1;
  endtask

  function automatic void add(input int fv, input int fi, input int fp, input int ft, input int fn,
      input int rv, input int rt, input int rtg, input int ue, input int ut, input int ui,
      input int utg, input int fl, input int rd, input int fu, input int em, input int er,
      input int br, input int mp);
    vec_t v;
    v.fv = 1'(fv); v.fi = 2'(fi); v.fp = 1'(fp); v.ft = 32'(ft); v.fn = 32'(fn);
    v.rv = 1'(rv); v.rt = 1'(rt); v.rtg = 32'(rtg);
    v.exp = pack(1'(ue), 1'(ut), 2'(ui), 32'(utg), 1'(fl), 32'(rd), 1'(fu), 1'(em), 1'(er),
                 16'(br), 16'(mp));
    vt.push_back(v);
  endfunction

  initial begin
    rst_v = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    //   fv fi fp ft      fn      rv rt rtg    | ue ut ui utg     fl rd      fu em er br mp
    add(1, 1, 0, 0,      'h104,  0, 0, 0,      0, 0, 0, 0,      0, 0,      0, 0, 0, 0, 0);
    add(0, 0, 0, 0,      0,      1, 1, 'h200,  1, 1, 1, 'h200,  1, 'h200,  0, 1, 0, 1, 1);
    add(1, 2, 1, 'h300,  'h108,  0, 0, 0,      0, 1, 1, 'h200,  1, 'h200,  0, 1, 0, 1, 1);
    add(1, 2, 1, 'h300,  'h108,  0, 0, 0,      0, 1, 1, 'h200,  1, 'h200,  0, 1, 0, 1, 1);
    add(1, 2, 1, 'h300,  'h108,  0, 0, 0,      0, 1, 1, 'h200,  0, 0,      0, 1, 0, 1, 1);
    add(1, 2, 1, 'h300,  'h108,  0, 0, 0,      0, 1, 1, 'h200,  0, 0,      0, 0, 0, 1, 1);
    add(0, 0, 0, 0,      0,      1, 1, 'h300,  1, 1, 2, 'h300,  0, 0,      0, 1, 0, 2, 1);
    add(1, 3, 1, 'h300,  'h10C,  0, 0, 0,      0, 1, 2, 'h300,  0, 0,      0, 0, 0, 2, 1);
    add(0, 0, 0, 0,      0,      1, 1, 'h340,  1, 1, 3, 'h340,  1, 'h340,  0, 1, 0, 3, 2);
    add(0, 0, 0, 0,      0,      0, 0, 0,      0, 1, 3, 'h340,  1, 'h340,  0, 1, 0, 3, 2);
    add(0, 0, 0, 0,      0,      0, 0, 0,      0, 1, 3, 'h340,  1, 'h340,  0, 1, 0, 3, 2);
    add(0, 0, 0, 0,      0,      0, 0, 0,      0, 1, 3, 'h340,  0, 0,      0, 1, 0, 3, 2);
    add(1, 0, 1, 'h400,  'h110,  0, 0, 0,      0, 1, 3, 'h340,  0, 0,      0, 0, 0, 3, 2);
    add(0, 0, 0, 0,      0,      1, 0, 0,      1, 0, 0, 0,      1, 'h110,  0, 1, 0, 4, 3);
    add(0, 0, 0, 0,      0,      0, 0, 0,      0, 0, 0, 0,      1, 'h110,  0, 1, 0, 4, 3);
    add(0, 0, 0, 0,      0,      0, 0, 0,      0, 0, 0, 0,      1, 'h110,  0, 1, 0, 4, 3);
    add(0, 0, 0, 0,      0,      0, 0, 0,      0, 0, 0, 0,      0, 0,      0, 1, 0, 4, 3);
    add(1, 0, 0, 0,      'h500,  0, 0, 0,      0, 0, 0, 0,      0, 0,      0, 0, 0, 4, 3);
    add(1, 1, 0, 0,      'h504,  0, 0, 0,      0, 0, 0, 0,      0, 0,      0, 0, 0, 4, 3);
    add(1, 2, 0, 0,      'h508,  0, 0, 0,      0, 0, 0, 0,      0, 0,      0, 0, 0, 4, 3);
    add(1, 3, 0, 0,      'h50C,  0, 0, 0,      0, 0, 0, 0,      0, 0,      1, 0, 0, 4, 3);
    add(1, 1, 0, 0,      'h5FF,  0, 0, 0,      0, 0, 0, 0,      0, 0,      1, 0, 1, 4, 3);
    add(1, 2, 0, 0,      'h510,  1, 0, 0,      1, 0, 0, 0,      0, 0,      1, 0, 1, 5, 3);
    add(0, 0, 0, 0,      0,      1, 0, 0,      1, 0, 1, 0,      0, 0,      0, 0, 1, 6, 3);
    add(1, 3, 0, 0,      'h520,  1, 1, 'h600,  1, 1, 2, 'h600,  1, 'h600,  0, 1, 1, 7, 4);
    add(1, 3, 0, 0,      'h520,  0, 0, 0,      0, 1, 2, 'h600,  1, 'h600,  0, 1, 1, 7, 4);
    add(1, 3, 0, 0,      'h520,  0, 0, 0,      0, 1, 2, 'h600,  1, 'h600,  0, 1, 1, 7, 4);
    add(1, 3, 0, 0,      'h520,  0, 0, 0,      0, 1, 2, 'h600,  0, 0,      0, 1, 1, 7, 4);
    add(1, 1, 0, 0,      'h700,  0, 0, 0,      0, 1, 2, 'h600,  0, 0,      0, 0, 1, 7, 4);
    add(0, 0, 0, 0,      0,      1, 0, 0,      1, 0, 1, 0,      0, 0,      0, 1, 1, 8, 4);

    do_reset();
    foreach (vt[i]) begin
      drive(vt[i].fv, vt[i].fi, vt[i].fp, vt[i].ft, vt[i].fn, vt[i].rv, vt[i].rt, vt[i].rtg);
      step($sformatf("model_vec%0d", i));
      check($sformatf("table_vec%0d", i), dut_vec(), vt[i].exp);
    end

    // resolve against an empty queue: error only, no update
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h200);
    step("res_empty");
    check("res_empty_err", 104'({bif.err, bif.upd_en, bif.br_count}), 104'({1'b1, 1'b0, 16'd0}));

    // reset dropped in the middle of a flush
    drive(1, 1, 0, 0, 32'h104, 0, 0, 0);
    step("pre_flush_push");
    drive(0, 0, 0, 0, 0, 1, 1, 32'h200);
    step("flush_start");
    check("flush_high", 104'({bif.flush, bif.redirect_pc}), 104'({1'b1, 32'h200}));
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset_idle");
    check("post_reset_quiet", dut_vec(), rst_v);

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h100 + 32'h40 * 32'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'h100 + 32'h40 * 32'($urandom_range(0, 1)));
      step($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/br_resolve_ctrl.md
# br_resolve_ctrl

Sequencing controller for the 4-entry 2-bit branch predictor. It records each prediction made at fetch in an in-order in-flight queue and compares it with the actual outcome when the branch resolves in execute. It then drives the predictor's table-update port and raises a pipeline flush with a redirect PC on misprediction. It sits between the fetch stage, the execute-stage branch unit and the predictor.

## Interface
Parameters:
- DEPTH, 4: in-flight queue entries; power of two, at least 2.
- FLUSH_CYCLES, 1: cycles the flush is held after a mispredict; at least 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  a branch was fetched this cycle and its prediction is recorded.
- fetch_index  in  2  predictor index used at fetch.
- fetch_predict  in  1  prediction given: 1 = taken.
- fetch_target  in  32  predicted target from the predictor.
- fetch_npc  in  32  fall-through PC (branch PC + 4).
- res_valid  in  1  the oldest in-flight branch resolved this cycle.
- res_taken  in  1  actual outcome.
- res_target  in  32  actual taken target.
- upd_en  out  1  predictor update strobe (drives br).
- upd_taken  out  1  outcome for the update (drives br_taken).
- upd_index  out  2  entry to update (drives index_update).
- upd_target  out  32  target to write (drives br_target_I).
- flush  out  1  squash the younger pipeline contents.
- redirect_pc  out  32  correct PC; valid while flush is 1.
- full  out  1  queue holds DEPTH entries.
- empty  out  1  queue holds 0 entries.
- err  out  1  sticky protocol error: overflow, or resolve while empty.
- br_count  out  16  resolved branches, saturating at 0xFFFF.
- mp_count  out  16  mispredicts, saturating at 0xFFFF.

## Operation
- The FIFO stores {index, predict, target, npc} per entry, with log2(DEPTH)+1-bit read/write pointers that wrap modulo 2·DEPTH. full/empty are combinational from the pointers.
- FSM has two states.
  - RUN: accepts pushes and pops.
  - FLUSH: pushes and resolves are ignored. A down-counter loaded with FLUSH_CYCLES is decremented each cycle; at 0 the FSM returns to RUN.
- Push happens in RUN when fetch_valid && !full. fetch_valid while full drops the push and sets err.
- Pop happens in RUN when res_valid && !empty. res_valid while empty sets err and has no other effect.
- On a pop against the head entry:
  - Register upd_en=1, upd_taken=res_taken, upd_index=head.index, upd_target=res_target.
  - br_count increments.
  - A mispredict is (head.predict != res_taken) || (head.predict && res_taken && head.target != res_target).
- On a mispredict:
  - mp_count increments.
  - Register flush=1 and redirect_pc = res_taken ? res_target : head.npc.
  - Clear the queue: both pointers go to 0, because younger entries are wrong-path.
  - Enter FLUSH.
  - A push in the same cycle is discarded and does not set err, even when the queue is full.
- A push and a correct-prediction pop in the same cycle both take effect, including when the queue is full (the pop frees a slot) or empty (the push is not popped until a later cycle).
- Counters saturate and never wrap.
- err clears only on reset.

## Timing
- Reset sets FSM=RUN, pointers=0, and all outputs to 0 except empty=1.
- upd_en is a one-cycle pulse in cycle N+1 for a pop in cycle N. upd_* hold their last values otherwise.
- flush rises in N+1 and stays high exactly FLUSH_CYCLES cycles. redirect_pc is stable throughout and returns to 0 when flush falls.
- The first push is accepted in the cycle after flush falls.
- full/empty reflect pointer state with zero latency. A push in cycle N shows in empty in N+1.
- Asserting nRST mid-flush clears everything immediately. No update pulse or flush is generated.

## Test plan
- Push index 1, predict=0, npc=0x104; resolve taken, target 0x200 → N+1: upd_en=1, upd_taken=1, upd_index=1, upd_target=0x200, flush=1, redirect_pc=0x200, mp_count=1, empty=1.
- Push predict=1, target 0x300; resolve taken, target 0x300 → upd_en pulse, flush stays 0, br_count=1, mp_count=0.
- Push predict=1, target 0x300; resolve taken, target 0x340 → flush=1, redirect_pc=0x340. Then predict=1; resolve not-taken → redirect_pc=npc.
- Fill 4 entries → full=1. Fifth push → dropped, err=1. Push and correct pop in the same cycle → count stays 4.
- Queue 3 entries, oldest mispredicts with fetch_valid high, FLUSH_CYCLES=3 → flush high 3 cycles, queue empty, fetch_valid ignored during FLUSH, first push accepted after flush falls.
- res_valid with queue empty → err=1, no upd_en. Drop nRST during flush → all outputs 0, empty=1.
